// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: op codes, FSM states and
// address-alignment helpers.
package mau_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } mau_state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return op <= OP_LBU;
    endfunction

    function automatic logic is_sub_store(input logic [2:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: selects and extends sub-word load data, and merges
// sub-word store data into a full memory word.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_result,
    output logic [31:0] st_merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_shift;

    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        byte_sel   = word[byte_shift +: 8];
        half_sel   = addr_lo[1] ? word[31:16] : word[15:0];

        case (op)
            OP_LH:   ld_result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_result = {16'h0000, half_sel};
            OP_LB:   ld_result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_result = {24'h000000, byte_sel};
            default: ld_result = word;
        endcase

        st_merged = word;
        if (op == OP_SB) begin
            st_merged[byte_shift +: 8] = wdata[7:0];
        end else if (op == OP_SH) begin
            if (addr_lo[1]) st_merged[31:16] = wdata[15:0];
            else            st_merged[15:0]  = wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-only data memory;
// sub-word stores run as a read cycle followed by a full-word write cycle.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_pc,
    output logic              req_ready,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rd
);

    // Handshake: a request transfers on a cycle where req_valid and req_ready
    // are both 1; the requester holds req_* stable until that cycle.

    mau_state_t        state, state_nxt;
    logic [ADDR_W-3:0] rmw_waddr;
    logic [31:0]       rmw_pc;
    logic [DATA_W-1:0] rmw_word;
    logic              accept;
    logic              misaligned;
    logic              capture;
    logic [DATA_W-1:0] ld_result;
    logic [DATA_W-1:0] st_merged;

    mau_lane_align u_lane_align (
        .op        (req_op),
        .addr_lo   (req_addr[1:0]),
        .word      (mem_rd),
        .wdata     (req_wdata),
        .ld_result (ld_result),
        .st_merged (st_merged)
    );

    assign misaligned = is_misaligned(req_op, req_addr[1:0]);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        mem_we    = 1'b0;
        mem_wd    = req_wdata;
        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_pc    = req_pc;

        case (state)
            ST_IDLE: begin
                req_ready = reset;
                accept    = req_valid && reset;
                if (accept && !misaligned) begin
                    if (req_op == OP_SW) begin
                        mem_we = 1'b1;
                    end else if (is_sub_store(req_op)) begin
                        capture   = 1'b1;
                        state_nxt = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                // Reset low aborts the write; the merged word is simply dropped.
                mem_we    = reset;
                mem_wd    = rmw_word;
                mem_addr  = {rmw_waddr, 2'b00};
                mem_pc    = rmw_pc;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            err       <= 1'b0;
            rmw_word  <= '0;
            rmw_waddr <= '0;
            rmw_pc    <= '0;
        end else begin
            state    <= state_nxt;
            ld_valid <= accept && !misaligned && is_load(req_op);
            err      <= accept && misaligned;
            if (accept && !misaligned && is_load(req_op)) begin
                ld_data <= ld_result;
            end
            if (capture) begin
                rmw_word  <= st_merged;
                rmw_waddr <= req_addr[ADDR_W-1:2];
                rmw_pc    <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory model, directed
// scenarios followed by randomized load/store traffic.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        req_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_pc;
    logic [31:0] mem_rd;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .req_ready(req_ready), .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_pc(mem_pc),
        .mem_rd(mem_rd)
    );

    // Word memory attached to the DUT
    logic [31:0] mem [0:1023];
    assign mem_rd = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wd;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:255];
    logic [31:0] exp_q[$];
    bit          m_ld = 0, m_err = 0, m_pend = 0, chk_zero = 0;
    logic [2:0]  p_op;
    logic [31:0] p_addr, p_wd, p_pc;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[7:2]) * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] a);
        if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        int i;
        logic [15:0] h;
        logic [7:0]  b;
        i = int'(a[7:0]);
        b = ref_mem[i];
        h = (i < 255) ? {ref_mem[i+1], ref_mem[i]} : 16'h0;
        case (op)
            OP_LW:   return ref_word(a);
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            OP_LB:   return {{24{b[7]}}, b};
            default: return {24'h0, b};
        endcase
    endfunction

    // Scoreboard: observes every cycle away from the active edge.
    always @(negedge clk) begin
        bit acc;
        int i;
        check("ld_valid", {31'd0, ld_valid}, {31'd0, m_ld});
        check("err", {31'd0, err}, {31'd0, m_err});
        if (m_ld) begin
            if (exp_q.size() > 0) check("ld_data", ld_data, exp_q.pop_front());
            else check("ld_queue_empty", 32'd0, 32'd1);
        end
        if (chk_zero) check("ld_data_rst", ld_data, 32'd0);
        chk_zero = 0;
        check("req_ready", {31'd0, req_ready}, {31'd0, reset && !m_pend});
        acc = req_valid && reset && !m_pend;
        m_ld = 0;
        m_err = 0;
        if (!reset) begin
            check("we_in_reset", {31'd0, mem_we}, 32'd0);
            m_pend = 0;
            exp_q.delete();
            chk_zero = 1;
        end else if (m_pend) begin
            i = int'(p_addr[7:0]);
            ref_mem[i] = p_wd[7:0];
            if (p_op == OP_SH) ref_mem[i+1] = p_wd[15:8];
            check("rmw_we", {31'd0, mem_we}, 32'd1);
            check("rmw_wd", mem_wd, ref_word(p_addr));
            check("rmw_addr", mem_addr, {p_addr[31:2], 2'b00});
            check("rmw_pc", mem_pc, p_pc);
            m_pend = 0;
        end else if (acc) begin
            check("req_addr_out", mem_addr, {req_addr[31:2], 2'b00});
            if (ref_misaligned(req_op, req_addr)) begin
                check("we_misaligned", {31'd0, mem_we}, 32'd0);
                m_err = 1;
            end else if (req_op <= OP_LBU) begin
                check("we_load", {31'd0, mem_we}, 32'd0);
                exp_q.push_back(ref_load(req_op, req_addr));
                m_ld = 1;
            end else if (req_op == OP_SW) begin
                check("sw_we", {31'd0, mem_we}, 32'd1);
                check("sw_wd", mem_wd, req_wdata);
                check("sw_pc", mem_pc, req_pc);
                i = int'(req_addr[7:0]);
                for (int k = 0; k < 4; k++) ref_mem[i+k] = req_wdata[8*k +: 8];
            end else begin
                check("we_rmw_read", {31'd0, mem_we}, 32'd0);
                m_pend = 1;
                p_op = req_op;
                p_addr = req_addr;
                p_wd = req_wdata;
                p_pc = req_pc;
            end
        end else begin
            check("we_idle", {31'd0, mem_we}, 32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output int waits);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_pc    = $urandom;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 8) begin
                check("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_op    = 3'($urandom_range(0, 7));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        logic [2:0]  op;
        logic [31:0] a;
        for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'd0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        issue(OP_SW, 32'h10, 32'h12345678, w);
        issue(OP_LW, 32'h10, 32'h0, w);

        issue(OP_SW, 32'h20, 32'h11223344, w);
        issue(OP_SB, 32'h21, 32'h000000AB, w);
        check("sb_wait", w, 0);
        issue(OP_LBU, 32'h21, 32'h0, w);
        check("lbu_wait", w, 1);
        check("sb_merge_word", mem[8], 32'h1122AB44);
        issue(OP_LB, 32'h21, 32'h0, w);

        issue(OP_SH, 32'h22, 32'h00008001, w);
        issue(OP_LH, 32'h22, 32'h0, w);
        check("sh_merge_word", mem[8], 32'h8001AB44);
        issue(OP_LHU, 32'h22, 32'h0, w);

        issue(OP_LW, 32'h13, 32'h0, w);
        issue(OP_SH, 32'h25, 32'hFFFF, w);
        idle(2);
        check("mis_mem_10", mem[4], 32'h12345678);
        check("mis_mem_24", mem[9], 32'h0);

        issue(OP_SB, 32'h30, 32'h000000CD, w);
        issue(OP_LW, 32'h30, 32'h0, w);
        check("held_lw_wait", w, 1);
        idle(2);

        // Reset in the write cycle of a sub-word store aborts the write.
        issue(OP_SW, 32'h40, 32'hA5A5A5A5, w);
        issue(OP_SB, 32'h40, 32'h11, w);
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);
        check("rst_abort_word", mem[16], 32'hA5A5A5A5);

        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = {a[31:2], 2'b00} | 32'($urandom_range(0, 1) * 2);
            issue(op, a, $urandom, w);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        for (int k = 0; k < 64; k++) check("final_mem", mem[k], ref_word(32'(k * 4)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
